// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory write bus for prog_loader.
// The host drives byte_in/byte_valid. The loader returns byte_ready and
// drives the instruction memory write port (imem_we/imem_addr/imem_wdata).
interface prog_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;

    // Host / memory side
    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    // Loader side
    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: receives a word count byte N (0 means 256), then N big-endian
// 32-bit words. Each word is written to instruction memory, and then the core
// is released from reset.
// Optional feature: when LOADER_CHECKSUM_EN is defined, a trailing modulo-256
// checksum byte of all data bytes is checked. A match releases the core;
// a mismatch parks the loader in ERR with err=1.
module prog_loader (
    input  logic         clk,
    input  logic         rst_n,
    prog_loader_if.slave bus,
    output logic         core_rst_n,
    output logic         done,
    output logic         err
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {HDR, LOAD, WRITE, CHK, RUN, ERR} state_t;
`else
    typedef enum logic [2:0] {HDR, LOAD, WRITE, RUN} state_t;
`endif

    state_t      state_reg, state_next;
    logic [7:0]  addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic [7:0]  word_cnt_reg, word_cnt_next;
    logic [7:0]  n_reg, n_next;
    logic        ready;
    logic        xfer;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_reg, csum_next;
`endif

    // The loader accepts bytes only while it waits for a header, data or checksum.
`ifdef LOADER_CHECKSUM_EN
    assign ready = (state_reg == HDR) || (state_reg == LOAD) || (state_reg == CHK);
    assign err   = (state_reg == ERR);
`else
    assign ready = (state_reg == HDR) || (state_reg == LOAD);
    assign err   = 1'b0;
`endif
    assign xfer           = ready && bus.byte_valid;
    assign bus.byte_ready = ready;
    assign bus.imem_we    = (state_reg == WRITE);
    assign bus.imem_addr  = addr_reg;
    assign bus.imem_wdata = wdata_reg;
    assign core_rst_n     = (state_reg == RUN);
    assign done           = (state_reg == RUN);

    // State and datapath registers; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= HDR;
            addr_reg     <= 8'd0;
            wdata_reg    <= 32'd0;
            byte_cnt_reg <= 2'd0;
            word_cnt_reg <= 8'd0;
            n_reg        <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_reg     <= 8'd0;
`endif
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            byte_cnt_reg <= byte_cnt_next;
            word_cnt_reg <= word_cnt_next;
            n_reg        <= n_next;
`ifdef LOADER_CHECKSUM_EN
            csum_reg     <= csum_next;
`endif
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        byte_cnt_next = byte_cnt_reg;
        word_cnt_next = word_cnt_reg;
        n_next        = n_reg;
`ifdef LOADER_CHECKSUM_EN
        csum_next     = csum_reg;
`endif
        case (state_reg)
            HDR: begin
                if (xfer) begin
                    n_next     = bus.byte_in;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (xfer) begin
                    wdata_next    = {wdata_reg[23:0], bus.byte_in};
                    byte_cnt_next = byte_cnt_reg + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_next     = csum_reg + bus.byte_in;
`endif
                    if (byte_cnt_reg == 2'd3) begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                addr_next     = addr_reg + 8'd1;
                word_cnt_next = word_cnt_reg + 8'd1;
                // A header of 0 wraps n_reg-1 to 255, so it gives 256 words.
                if (word_cnt_reg == n_reg - 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = CHK;
`else
                    state_next = RUN;
`endif
                end else begin
                    state_next = LOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer) begin
                    state_next = (bus.byte_in == csum_reg) ? RUN : ERR;
                end
            end
            ERR: state_next = ERR;
`endif
            RUN: state_next = RUN;
            default: state_next = HDR;
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
// Builds in both configurations. When LOADER_CHECKSUM_EN is defined, the
// checksum byte is sent and the checksum pass/fail scenarios are exercised.
`timescale 1ns/1ps
module tb_prog_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic core_rst_n, done, err;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    prog_loader_if bus();

    prog_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .core_rst_n (core_rst_n),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Record every memory write seen on the bus.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr_q.push_back(bus.imem_addr);
            wr_data_q.push_back(bus.imem_wdata);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        bus.byte_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // Offers one byte and waits (with a bound) until the loader accepts it.
    // The task returns 1ns after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        bit sent;
        sent = 1'b0;
        bus.byte_in = b;
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 20 && !sent; i++) begin
            @(negedge clk);
            sent = (bus.byte_ready === 1'b1);
            @(posedge clk); #1;
        end
        bus.byte_valid = 1'b0;
        if (!sent) begin
            total_cnt++;
            $display("FAIL send_timeout: byte %h not accepted within 20 cycles", b);
        end
    endtask

    task automatic test_reset();
        bus.byte_in = 8'hFF;
        bus.byte_valid = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (bus.imem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", bus.imem_we); else pass_cnt++;
        total_cnt++; if (core_rst_n !== 1'b0) $display("FAIL rst_core_rst_n: got %b want 0", core_rst_n); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else pass_cnt++;
        total_cnt++; if (bus.imem_addr !== 8'h00) $display("FAIL rst_addr: got %h want 00", bus.imem_addr); else pass_cnt++;
        total_cnt++; if (bus.imem_wdata !== 32'h0) $display("FAIL rst_wdata: got %h want 00000000", bus.imem_wdata); else pass_cnt++;
        bus.byte_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++; if (bus.byte_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.byte_ready); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_single_word();
        do_reset();
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        // Cycle t+1 after the 4th transfer: the write cycle
        total_cnt++; if (bus.imem_we !== 1'b1) $display("FAIL sw_we: got %b want 1", bus.imem_we); else pass_cnt++;
        total_cnt++; if (bus.imem_addr !== 8'h00) $display("FAIL sw_addr: got %h want 00", bus.imem_addr); else pass_cnt++;
        total_cnt++; if (bus.imem_wdata !== 32'h12345678) $display("FAIL sw_wdata: got %h want 12345678", bus.imem_wdata); else pass_cnt++;
        total_cnt++; if (bus.byte_ready !== 1'b0) $display("FAIL sw_ready_in_write: got %b want 0", bus.byte_ready); else pass_cnt++;
        total_cnt++; if (core_rst_n !== 1'b0) $display("FAIL sw_core_held: got %b want 0", core_rst_n); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (bus.imem_we !== 1'b0) $display("FAIL sw_we_one_cycle: got %b want 0", bus.imem_we); else pass_cnt++;
`ifdef LOADER_CHECKSUM_EN
        total_cnt++; if (bus.byte_ready !== 1'b1) $display("FAIL sw_chk_ready: got %b want 1", bus.byte_ready); else pass_cnt++;
        send_byte(8'h14);
`endif
        total_cnt++; if (core_rst_n !== 1'b1) $display("FAIL sw_core_released: got %b want 1", core_rst_n); else pass_cnt++;
        total_cnt++; if (done !== 1'b1) $display("FAIL sw_done: got %b want 1", done); else pass_cnt++;
        total_cnt++; if (bus.byte_ready !== 1'b0) $display("FAIL sw_run_ready: got %b want 0", bus.byte_ready); else pass_cnt++;
        total_cnt++; if (wr_addr_q.size() !== 1) $display("FAIL sw_write_count: got %0d want 1", wr_addr_q.size()); else pass_cnt++;
    endtask

    task automatic test_toggle_valid();
        logic [7:0] bytes [8];
        bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
        do_reset();
        send_byte(8'h02);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;               // idle cycle: byte_valid low
            send_byte(bytes[i]);
            if (i % 4 == 3) begin
                total_cnt++;
                if (bus.imem_we !== 1'b1 || bus.byte_ready !== 1'b0)
                    $display("FAIL tg_write_cycle%0d: we=%b ready=%b want we=1 ready=0", i / 4, bus.imem_we, bus.byte_ready);
                else pass_cnt++;
            end
        end
`ifdef LOADER_CHECKSUM_EN
        @(posedge clk); #1;
        send_byte(8'h18);
`else
        @(posedge clk); #1;
`endif
        total_cnt++; if (wr_addr_q.size() !== 2) $display("FAIL tg_write_count: got %0d want 2", wr_addr_q.size()); else pass_cnt++;
        if (wr_addr_q.size() == 2) begin
            total_cnt++; if (wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 32'hAABBCCDD) $display("FAIL tg_word0: got %h/%h want 00/aabbccdd", wr_addr_q[0], wr_data_q[0]); else pass_cnt++;
            total_cnt++; if (wr_addr_q[1] !== 8'h01 || wr_data_q[1] !== 32'h01020304) $display("FAIL tg_word1: got %h/%h want 01/01020304", wr_addr_q[1], wr_data_q[1]); else pass_cnt++;
        end
        total_cnt++; if (done !== 1'b1) $display("FAIL tg_done: got %b want 1", done); else pass_cnt++;
    endtask

    task automatic test_full_256();
        int bad;
        logic [7:0] b0;
        do_reset();
        send_byte(8'h00);
        for (int i = 0; i < 1024; i++) send_byte(i[7:0]);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00);                     // 4 * sum(0..255) mod 256
`else
        @(posedge clk); #1;
`endif
        total_cnt++; if (wr_addr_q.size() !== 256) $display("FAIL full_write_count: got %0d want 256", wr_addr_q.size()); else pass_cnt++;
        if (wr_addr_q.size() == 256) begin
            bad = 0;
            for (int k = 0; k < 256; k++) begin
                b0 = 8'(4 * k);
                if (wr_addr_q[k] !== 8'(k) ||
                    wr_data_q[k] !== {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3}) bad++;
            end
            total_cnt++; if (bad != 0) $display("FAIL full_contents: got %0d bad words want 0", bad); else pass_cnt++;
            total_cnt++; if (wr_addr_q[255] !== 8'hFF || wr_data_q[255] !== 32'hFCFDFEFF) $display("FAIL full_last: got %h/%h want ff/fcfdfeff", wr_addr_q[255], wr_data_q[255]); else pass_cnt++;
        end
        total_cnt++; if (done !== 1'b1) $display("FAIL full_done: got %b want 1", done); else pass_cnt++;
        total_cnt++; if (bus.imem_addr !== 8'h00) $display("FAIL full_addr_wrap: got %h want 00", bus.imem_addr); else pass_cnt++;
    endtask

    task automatic test_abort_reload();
        do_reset();
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        do_reset();
        total_cnt++; if (bus.imem_wdata !== 32'h0) $display("FAIL ab_wdata_cleared: got %h want 00000000", bus.imem_wdata); else pass_cnt++;
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
`ifdef LOADER_CHECKSUM_EN
        @(posedge clk); #1;
        send_byte(8'h38);
`else
        @(posedge clk); #1;
`endif
        total_cnt++; if (wr_addr_q.size() !== 1) $display("FAIL ab_write_count: got %0d want 1", wr_addr_q.size()); else pass_cnt++;
        if (wr_addr_q.size() == 1) begin
            total_cnt++; if (wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 32'hDEADBEEF) $display("FAIL ab_word: got %h/%h want 00/deadbeef", wr_addr_q[0], wr_data_q[0]); else pass_cnt++;
        end
        total_cnt++; if (done !== 1'b1) $display("FAIL ab_done: got %b want 1", done); else pass_cnt++;
    endtask

    // Runs while the loader is in RUN after the previous scenario.
    task automatic test_run_ignores_bytes();
        int writes_before;
        writes_before = wr_addr_q.size();
        bus.byte_in = 8'hFF;
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total_cnt++;
            if (bus.imem_we !== 1'b0 || bus.byte_ready !== 1'b0 || done !== 1'b1 || core_rst_n !== 1'b1)
                $display("FAIL run_ignore_c%0d: we=%b ready=%b done=%b core_rst_n=%b want 0 0 1 1", i, bus.imem_we, bus.byte_ready, done, core_rst_n);
            else pass_cnt++;
        end
        bus.byte_valid = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if (wr_addr_q.size() !== writes_before) $display("FAIL run_no_writes: got %0d want %0d", wr_addr_q.size(), writes_before); else pass_cnt++;
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            send_byte(8'h01);
            send_byte(8'h01);
            send_byte(8'h02);
            send_byte(8'h03);
            send_byte(8'h04);
            @(posedge clk); #1;
            send_byte(pass == 0 ? 8'h0A : 8'h0B);
            if (pass == 0) begin
                total_cnt++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL cs_good: done=%b err=%b want 1 0", done, err); else pass_cnt++;
            end else begin
                total_cnt++; if (err !== 1'b1 || core_rst_n !== 1'b0 || bus.byte_ready !== 1'b0 || done !== 1'b0)
                    $display("FAIL cs_bad: err=%b core_rst_n=%b ready=%b done=%b want 1 0 0 0", err, core_rst_n, bus.byte_ready, done);
                else pass_cnt++;
            end
        end
    endtask
`endif

    initial begin
        bus.byte_in = 8'h00;
        bus.byte_valid = 1'b0;
        test_reset();
        test_single_word();
        test_toggle_valid();
        test_full_256();
        test_abort_reload();
        test_run_ignores_bytes();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have ports clk input 1 (system clock; all logic on rising edge) and rst_n input 1 (reset; synchronous, active-low).
REQ-002 SHALL have port byte_in input 8 (serial program byte from host).
REQ-003 SHALL have port byte_valid input 1 (byte_in holds a valid byte).
REQ-004 SHALL have port byte_ready output 1 (loader accepts a byte this cycle).
REQ-005 SHALL have port imem_we output 1 (one-cycle write strobe to instruction memory).
REQ-006 SHALL have port imem_addr output 8 (instruction memory word address).
REQ-007 SHALL have port imem_wdata output 32 (assembled instruction word).
REQ-008 SHALL have port core_rst_n output 1 (processor reset; low holds the core in reset).
REQ-009 SHALL have port done output 1 (program loaded; core released).
REQ-010 SHALL have port err output 1 (checksum mismatch; see Configuration).

Function
REQ-011 SHALL accept a byte only on a cycle where byte_valid and byte_ready are both high (a transfer).
REQ-012 SHALL implement states HDR, LOAD, WRITE, CHK, RUN, ERR; byte_ready is high only in HDR, LOAD and CHK.
REQ-013 HDR: the first transfer SHALL be the word count N; N=0 means 256 words; next state LOAD.
REQ-014 LOAD: transfers SHALL be shifted in big-endian, so the first byte lands in imem_wdata[31:24] and the fourth in [7:0].
REQ-015 On the fourth byte of a word, the next state SHALL be WRITE.
REQ-016 WRITE SHALL last exactly one cycle, with imem_we=1 and imem_addr/imem_wdata stable.
REQ-017 Timing: 4th-byte transfer at edge t -> imem_we high in cycle t+1 -> byte_ready high again in cycle t+2.
REQ-018 imem_addr SHALL start at 0 and increment by 1 after each WRITE, wrapping 255->0.
REQ-019 After the WRITE of word N, the next state SHALL be CHK if LOADER_CHECKSUM_EN is defined, otherwise RUN.
REQ-020 RUN: core_rst_n=1, done=1, byte_ready=0; the state persists until rst_n is asserted.
REQ-021 In all states other than RUN, core_rst_n SHALL be 0 and done SHALL be 0.
REQ-022 byte_valid asserted while byte_ready=0 SHALL be ignored, and no state shall change.
REQ-023 Gaps in byte_valid between transfers SHALL be tolerated for any length, with no timeout.
REQ-024 imem_we SHALL be 0 in every state except WRITE.

Reset
REQ-025 When rst_n=0 at a rising edge, the next state SHALL be: state HDR, imem_addr=0, imem_wdata=0, byte counter=0, word counter=0, checksum=0.
REQ-026 Outputs during and after that reset edge: imem_we=0, core_rst_n=0, done=0, err=0; byte_ready=1 once rst_n=1.
REQ-027 Reset mid-load or in RUN/ERR SHALL abort and discard any partial word; the next transfer is treated as a new header.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN defined: after word N the loader SHALL accept one checksum byte in CHK.
REQ-029 With LOADER_CHECKSUM_EN, the running checksum SHALL be the 8-bit modulo-256 sum of all data bytes, header excluded.
REQ-030 With LOADER_CHECKSUM_EN: match -> RUN; mismatch -> ERR.
REQ-031 With LOADER_CHECKSUM_EN, ERR SHALL hold err=1, core_rst_n=0, byte_ready=0 until reset.
REQ-032 Macro LOADER_CHECKSUM_EN undefined: no CHK or ERR logic, err tied to 0, and a checksum byte is never consumed.

Verification
REQ-033 N=1, bytes 0x12,0x34,0x56,0x78 -> one imem_we pulse, addr 0x00, data 0x12345678; core_rst_n=1 two cycles after the 4th transfer (macro off).
REQ-034 N=2, words 0xAABBCCDD and 0x01020304, byte_valid toggling every other cycle -> writes at addr 0 then addr 1 with correct data; byte_ready=0 during each WRITE cycle.
REQ-035 N=0, 1024 incrementing data bytes -> 256 writes, addr 0..255; the last write is at addr 0xFF, then done=1.
REQ-036 Reset after 2 data bytes of the first word, then N=1 with 0xDEADBEEF -> a single write at addr 0 with data 0xDEADBEEF; no partial word written.
REQ-037 Macro on: N=1, data 0x01,0x02,0x03,0x04 -> checksum byte 0x0A gives done=1; checksum byte 0x0B gives err=1, core_rst_n=0, byte_ready=0.
REQ-038 In RUN, byte_valid=1 with byte_in=0xFF for 10 cycles -> no transfer, no imem_we, state unchanged.
